// File: rtl/fir_sample_src.sv
// Cyclic sample-table player feeding the FIR xin/en input.
// Plays a loadable DEPTH-entry table in finite bursts or continuously.

module fir_sample_src_chk (
  input logic clk,
  input logic rstn,
  input logic en,
  input logic busy,
  input logic done
);
  a_done_idle : assert property (@(posedge clk) disable iff (!rstn) done |-> (!en && !busy));
  a_done_once : assert property (@(posedge clk) disable iff (!rstn) done |=> !done);
  a_en_busy   : assert property (@(posedge clk) disable iff (!rstn) en |-> busy);
endmodule

module fir_sample_src #(
  parameter int DW    = 12,
  parameter int DEPTH = 200,
  parameter int AW    = 8,
  parameter int BLW   = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           wr_en,
  input  logic [AW-1:0]  wr_addr,
  input  logic [DW-1:0]  wr_data,
  input  logic           start,
  input  logic           stop,
  input  logic [BLW-1:0] burst_len,
  output logic           en,
  output logic [DW-1:0]  xout,
  output logic           busy,
  output logic           done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    if (a == LAST_ADDR) begin
      next_addr = {AW{1'b0}};
    end else begin
      next_addr = a + {{(AW-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [DW-1:0]  mem [DEPTH];
  state_t         state_r;
  logic [AW-1:0]  rd_addr_r;
  logic [BLW-1:0] len_r;
  logic [BLW-1:0] cnt_r;
  logic           en_r;
  logic [DW-1:0]  xout_r;
  logic           busy_r;
  logic           done_r;
  logic           wr_ok_s;
  logic           finite_s;

  assign wr_ok_s  = wr_en && (wr_addr <= LAST_ADDR);
  assign finite_s = (len_r != {BLW{1'b0}});

  // Table RAM: unreset, write-only port here; reads in the FSM see pre-write data.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Playback FSM with registered stream and status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      rd_addr_r <= {AW{1'b0}};
      len_r     <= {BLW{1'b0}};
      cnt_r     <= {BLW{1'b0}};
      en_r      <= 1'b0;
      xout_r    <= {DW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          en_r   <= 1'b0;
          done_r <= 1'b0;
          if (start && !stop) begin
            state_r   <= ST_RUN;
            busy_r    <= 1'b1;
            len_r     <= burst_len;
            cnt_r     <= {BLW{1'b0}};
            rd_addr_r <= {AW{1'b0}};
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RUN: begin
          // stop wins over a burst that completes on the same edge: no done pulse.
          if (stop) begin
            state_r   <= ST_IDLE;
            en_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            rd_addr_r <= {AW{1'b0}};
            cnt_r     <= {BLW{1'b0}};
          end else if (finite_s && (cnt_r == len_r)) begin
            state_r   <= ST_IDLE;
            en_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            rd_addr_r <= {AW{1'b0}};
            cnt_r     <= {BLW{1'b0}};
          end else begin
            en_r      <= 1'b1;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            xout_r    <= mem[rd_addr_r];
            rd_addr_r <= next_addr(rd_addr_r);
            if (finite_s) begin
              cnt_r <= cnt_r + {{(BLW-1){1'b0}}, 1'b1};
            end else begin
              cnt_r <= cnt_r;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          en_r      <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          rd_addr_r <= {AW{1'b0}};
          cnt_r     <= {BLW{1'b0}};
        end
      endcase
    end
  end

  assign en   = en_r;
  assign xout = xout_r;
  assign busy = busy_r;
  assign done = done_r;

  fir_sample_src_chk u_chk (
    .clk  (clk),
    .rstn (rstn),
    .en   (en_r),
    .busy (busy_r),
    .done (done_r)
  );

endmodule

// File: tb/tb_fir_sample_src.sv
// Self-checking bench for fir_sample_src: table vectors, corner sequences and
// randomized bursts checked against a table-indexed reference model.

module tb_fir_sample_src;
  localparam int DW    = 12;
  localparam int DEPTH = 200;
  localparam int AW    = 8;
  localparam int BLW   = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           start;
  logic           stop;
  logic [BLW-1:0] burst_len;
  logic           en;
  logic [DW-1:0]  xout;
  logic           busy;
  logic           done;

  logic [DW-1:0] model [DEPTH];
  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int len;
    int stop_after;
    bit mid_start;
    int exp_n;
    bit exp_done;
  } vec_t;

  vec_t vecs [8];

  fir_sample_src #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .BLW(BLW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .en        (en),
    .xout      (xout),
    .busy      (busy),
    .done      (done)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic load_table(input bit rnd);
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = rnd ? DW'($urandom_range(0, 4095)) : DW'(i);
      step();
      model[i] = wr_data;
    end
    wr_en = 1'b0;
  endtask

  task automatic do_start(input int len);
    start     = 1'b1;
    stop      = 1'b0;
    burst_len = BLW'(len);
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_en", 32'(en), 32'd0);
    chk("start_done", 32'(done), 32'd0);
  endtask

  // Sample j of a burst (1-based) must be table entry (j-1) mod DEPTH.
  task automatic stream(input int n_exp, input int stop_after, input bit mid_start);
    for (int j = 1; j <= n_exp; j++) begin
      step();
      start = 1'b0;
      stop  = 1'b0;
      chk("run_en", 32'(en), 32'd1);
      chk("run_xout", 32'(xout), 32'(model[(j - 1) % DEPTH]));
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
      if (mid_start && j == 3) start = 1'b1;
      if (stop_after != 0 && j == stop_after) stop = 1'b1;
    end
  endtask

  task automatic end_check(input bit exp_done);
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk("end_en", 32'(en), 32'd0);
    chk("end_done", 32'(done), 32'(exp_done));
    chk("end_busy", 32'(busy), 32'd0);
  endtask

  task automatic done_drop();
    step();
    chk("done_drop", 32'(done), 32'd0);
    chk("idle_en", 32'(en), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; burst_len = '0;

    vecs[0] = '{len: 5,   stop_after: 0,   mid_start: 1'b0, exp_n: 5,   exp_done: 1'b1};
    vecs[1] = '{len: 0,   stop_after: 450, mid_start: 1'b0, exp_n: 450, exp_done: 1'b0};
    vecs[2] = '{len: 0,   stop_after: 38,  mid_start: 1'b0, exp_n: 38,  exp_done: 1'b0};
    vecs[3] = '{len: 10,  stop_after: 4,   mid_start: 1'b0, exp_n: 4,   exp_done: 1'b0};
    vecs[4] = '{len: 1,   stop_after: 0,   mid_start: 1'b0, exp_n: 1,   exp_done: 1'b1};
    vecs[5] = '{len: 200, stop_after: 0,   mid_start: 1'b0, exp_n: 200, exp_done: 1'b1};
    vecs[6] = '{len: 201, stop_after: 0,   mid_start: 1'b1, exp_n: 201, exp_done: 1'b1};
    vecs[7] = '{len: 7,   stop_after: 0,   mid_start: 1'b1, exp_n: 7,   exp_done: 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_xout", 32'(xout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rstn = 1'b1;
    step();

    load_table(1'b0);

    foreach (vecs[i]) begin
      do_start(vecs[i].len);
      stream(vecs[i].exp_n, vecs[i].stop_after, vecs[i].mid_start);
      end_check(vecs[i].exp_done);
      done_drop();
    end

    // start and stop together in IDLE must not launch playback
    start = 1'b1; stop = 1'b1; burst_len = BLW'(5);
    step();
    chk("ss_busy", 32'(busy), 32'd0);
    step();
    chk("ss_en", 32'(en), 32'd0);
    start = 1'b0; stop = 1'b0;
    step();
    chk("ss_en2", 32'(en), 32'd0);

    // back-to-back bursts: start accepted while done is high
    do_start(3);
    stream(3, 0, 1'b0);
    end_check(1'b1);
    start = 1'b1; burst_len = BLW'(2);
    step();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done", 32'(done), 32'd0);
    stream(2, 0, 1'b0);
    end_check(1'b1);
    done_drop();

    // asynchronous reset in the middle of a burst
    do_start(10);
    stream(3, 0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("arst_en", 32'(en), 32'd0);
    chk("arst_xout", 32'(xout), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    step();
    step();
    rstn = 1'b1;
    step();
    chk("post_rst_en", 32'(en), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    do_start(2);
    stream(2, 0, 1'b0);
    end_check(1'b1);
    done_drop();

    // writes during playback: out-of-range ignored, same-address read-first
    do_start(0);
    for (int j = 1; j <= 260; j++) begin
      step();
      wr_en = 1'b0;
      chk("wr_en_hi", 32'(en), 32'd1);
      chk("wr_xout", 32'(xout), 32'(model[(j - 1) % DEPTH]));
      if (j == 51) model[50] = 12'hABC;
      if (j == 10) begin
        wr_en = 1'b1; wr_addr = 8'd200; wr_data = 12'hFFF;
      end
      if (j == 50) begin
        wr_en = 1'b1; wr_addr = 8'd50; wr_data = 12'hABC;
      end
    end
    stop = 1'b1;
    end_check(1'b0);
    done_drop();

    // randomized bursts over random table contents
    for (int it = 0; it < 6; it++) begin
      int mode;
      int len;
      int stp;
      load_table(1'b1);
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        len = int'($urandom_range(1, 300)); stp = 0;
      end else if (mode == 1) begin
        len = 0; stp = int'($urandom_range(1, 300));
      end else begin
        len = int'($urandom_range(20, 300)); stp = int'($urandom_range(1, len - 1));
      end
      do_start(len);
      stream((stp != 0) ? stp : len, stp, 1'b0);
      end_check(stp == 0);
      done_drop();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
